// File: rtl/act_feed_addr_gen.sv
// Activation-buffer read address generator: streams N addresses per lane with a
// one-cycle-per-lane diagonal skew, plus read-latency-aligned valid strobes.

module act_feed_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  vld
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= 1'b0;
            vld  <= 1'b0;
            addr <= '0;
        end else if (clr) begin
            en  <= 1'b0;
            vld <= 1'b0;
        end else begin
            en  <= en_in;
            vld <= en;
            // address holds its last value while the lane is idle
            if (en_in) addr <= addr_in;
        end
    end
endmodule

module act_feed_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_DIM    = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         A_base_addr,
    input  logic [LEN_WIDTH-1:0]          num_vec,
    output logic [COL_DIM*ADDR_WIDTH-1:0] A_rd_addr,
    output logic [COL_DIM-1:0]            A_rd_en,
    output logic [COL_DIM-1:0]            lane_valid,
    output logic                          array_active,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t                           state, state_nxt;
    logic [ADDR_WIDTH-1:0]            base_q, base_nxt;
    logic [LEN_WIDTH-1:0]             n_q, n_nxt, cnt, cnt_nxt;
    logic                             done_q, done_nxt;
    logic                             flush;
    logic                             feed_en;
    logic [ADDR_WIDTH-1:0]            feed_addr;
    logic [COL_DIM-1:0]               lane_en;
    logic [COL_DIM-1:0][ADDR_WIDTH-1:0] lane_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            base_q <= '0;
            n_q    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            base_q <= base_nxt;
            n_q    <= n_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // feed_en/feed_addr are the values lane 0 takes on the next edge
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        n_nxt     = n_q;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        flush     = 1'b0;
        feed_en   = 1'b0;
        feed_addr = base_q + ADDR_WIDTH'(cnt);
        if (abort) begin
            state_nxt = IDLE;
            flush     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_nxt = A_base_addr;
                        n_nxt    = num_vec;
                        cnt_nxt  = '0;
                        if (num_vec == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            feed_en   = 1'b1;
                            feed_addr = A_base_addr;
                            cnt_nxt   = LEN_WIDTH'(1);
                            state_nxt = FEED;
                        end
                    end
                end
                FEED: begin
                    if (cnt == n_q) begin
                        state_nxt = DRAIN;
                    end else begin
                        feed_en = 1'b1;
                        cnt_nxt = cnt + LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // once every enable is low, lane_valid is low from the next cycle on,
                    // so done lands in the first cycle with the whole array quiet
                    if (lane_en == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < COL_DIM; i++) begin : g_lane
        if (i == 0) begin : g_head
            act_feed_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .clk(clk), .rst_n(reset), .clr(flush),
                .en_in(feed_en), .addr_in(feed_addr),
                .en(lane_en[i]), .addr(lane_addr[i]), .vld(lane_valid[i])
            );
        end else begin : g_tail
            act_feed_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .clk(clk), .rst_n(reset), .clr(flush),
                .en_in(lane_en[i-1]), .addr_in(lane_addr[i-1]),
                .en(lane_en[i]), .addr(lane_addr[i]), .vld(lane_valid[i])
            );
        end
    end

    assign A_rd_addr    = lane_addr;
    assign A_rd_en      = lane_en;
    assign array_active = |lane_valid;
    assign busy         = (state != IDLE);
    assign done         = done_q;
endmodule

// File: tb/tb_act_feed_addr_gen.sv
// Directed bench for act_feed_addr_gen: timing windows, wrap, zero length,
// ignored/back-to-back start, abort and asynchronous reset.

module tb_act_feed_addr_gen;
    localparam int AW = 10;
    localparam int CD = 16;
    localparam int LW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [AW-1:0]  A_base_addr;
    logic [LW-1:0]  num_vec;
    logic [CD*AW-1:0] A_rd_addr;
    logic [CD-1:0]  A_rd_en;
    logic [CD-1:0]  lane_valid;
    logic           array_active;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    act_feed_addr_gen #(.ADDR_WIDTH(AW), .COL_DIM(CD), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .A_base_addr(A_base_addr), .num_vec(num_vec),
        .A_rd_addr(A_rd_addr), .A_rd_en(A_rd_en), .lane_valid(lane_valid),
        .array_active(array_active), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lane_addr(input int i);
        return A_rd_addr[i*AW +: AW];
    endfunction

    // expected windows follow the cycle numbering with cycle 0 = start sample edge
    task automatic cyc_check(input int t, input logic [AW-1:0] base, input int n);
        logic [CD-1:0] een, evl;
        logic [AW-1:0] ea;
        for (int i = 0; i < CD; i++) begin
            een[i] = (t >= 1 + i) && (t <= n + i);
            evl[i] = (t >= 2 + i) && (t <= n + i + 1);
        end
        chk("rd_en", t, A_rd_en, een);
        chk("lane_valid", t, lane_valid, evl);
        chk("array_active", t, array_active, (t >= 2) && (t <= n + CD));
        chk("busy", t, busy, (t >= 1) && (t <= n + CD));
        chk("done", t, done, t == n + CD + 1);
        for (int i = 0; i < CD; i++) begin
            if (een[i]) begin
                ea = base + AW'(t - 1 - i);
                chk($sformatf("addr lane%0d", i), t, lane_addr(i), ea);
            end
        end
    endtask

    // Caller has start/base/num_vec set up for edge 0; returns in the done cycle.
    task automatic run(input logic [AW-1:0] base, input int n, input bit junk,
                       input bit chain, input logic [AW-1:0] nb, input int nn);
        step();
        start = 1'b0;
        for (int t = 1; t <= n + CD + 1; t++) begin
            cyc_check(t, base, n);
            if (junk && t == 3) begin
                start = 1'b1; A_base_addr = 10'h2AA; num_vec = 8'd9;
            end else if (junk && t == 4) begin
                start = 1'b0;
            end
            if (chain && t == n + CD + 1) begin
                start = 1'b1; A_base_addr = nb; num_vec = LW'(nn);
            end
            if (t < n + CD + 1) step();
        end
    endtask

    task automatic all_zero(input string tag, input int t);
        chk({tag, " rd_en"}, t, A_rd_en, '0);
        chk({tag, " lane_valid"}, t, lane_valid, '0);
        chk({tag, " array_active"}, t, array_active, 1'b0);
        chk({tag, " busy"}, t, busy, 1'b0);
        chk({tag, " done"}, t, done, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        A_base_addr = '0; num_vec = '0;
        #3;
        all_zero("reset", 0);
        chk("reset addr lo", 0, A_rd_addr[63:0], '0);
        chk("reset addr hi", 0, 64'(A_rd_addr[CD*AW-1:CD*AW-64]), '0);
        step(); step();
        reset = 1'b1;
        step();

        // basic run with an ignored start in cycle 3, chained into a second run
        start = 1'b1; A_base_addr = 10'h010; num_vec = 8'd4;
        run(10'h010, 4, 1'b1, 1'b1, 10'h100, 2);
        chk("hold lane0", 21, lane_addr(0), 10'h013);
        chk("hold lane15", 21, lane_addr(15), 10'h013);
        run(10'h100, 2, 1'b0, 1'b0, '0, 0);
        chk("hold lane0 run2", 19, lane_addr(0), 10'h101);
        step();

        // wrap-around
        start = 1'b1; A_base_addr = 10'h3FE; num_vec = 8'd4;
        run(10'h3FE, 4, 1'b0, 1'b0, '0, 0);
        chk("wrap hold lane7", 21, lane_addr(7), 10'h001);
        step();

        // zero length
        start = 1'b1; A_base_addr = 10'h155; num_vec = 8'd0;
        step();
        start = 1'b0;
        chk("zero done", 1, done, 1'b1);
        chk("zero busy", 1, busy, 1'b0);
        chk("zero rd_en", 1, A_rd_en, '0);
        chk("zero active", 1, array_active, 1'b0);
        step();
        all_zero("zero c2", 2);

        // simultaneous start and abort in IDLE
        start = 1'b1; abort = 1'b1; A_base_addr = 10'h020; num_vec = 8'd3;
        step();
        start = 1'b0; abort = 1'b0;
        all_zero("start+abort", 1);
        step();
        all_zero("start+abort", 2);

        // abort in cycle 5 of an N=8 run
        start = 1'b1; A_base_addr = 10'h040; num_vec = 8'd8;
        step();
        start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            cyc_check(t, 10'h040, 8);
            if (t < 5) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int t = 6; t <= 30; t++) begin
            all_zero("abort", t);
            step();
        end

        // asynchronous reset between edges during FEED
        start = 1'b1; A_base_addr = 10'h080; num_vec = 8'd8;
        step();
        start = 1'b0;
        step(); step();
        chk("pre-reset rd_en0", 3, A_rd_en[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        all_zero("async reset", 3);
        chk("async reset addr lo", 3, A_rd_addr[63:0], '0);
        @(posedge clk);
        #1 reset = 1'b1;
        start = 1'b1; A_base_addr = 10'h0C0; num_vec = 8'd2;
        run(10'h0C0, 2, 1'b0, 1'b0, '0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
